// File: rtl/skel_pkg.sv
// Shared types for the skeletonisation frame store: pixel type and controller states.
package skel_pkg;

    localparam int PIXEL_W = 8;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        COLLECT,
        CHECK,
        DONE
    } state_t;

endpackage

// File: rtl/skeleton_frame_store_if.sv
// Host, mask-stream and write-back signals of the frame store, bundled for one port.
interface skeleton_frame_store_if #(
    parameter int ADDR_W = 7
);
    import skel_pkg::*;

    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    pixel_t            host_wdata;
    pixel_t            host_rdata;

    logic              start;
    logic              busy;
    logic              done;
    logic [7:0]        pass_count;
    logic              converged;

    logic              mask_we;
    logic [ADDR_W-1:0] mask_addr;
    pixel_t            mask_data;

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    pixel_t            wb_data;

    modport slave (
        input  host_we, host_addr, host_wdata, start, wb_valid, wb_addr, wb_data,
        output host_rdata, busy, done, pass_count, converged, mask_we, mask_addr, mask_data
    );

    modport master (
        output host_we, host_addr, host_wdata, start, wb_valid, wb_addr, wb_data,
        input  host_rdata, busy, done, pass_count, converged, mask_we, mask_addr, mask_data
    );

endinterface

// File: rtl/frame_ram.sv
// Frame storage: one write port, one combinational read port and a registered host read port.
module frame_ram
    import skel_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  pixel_t            wdata,
    input  logic [ADDR_W-1:0] raddr,
    output pixel_t            rdata,
    input  logic [ADDR_W-1:0] host_addr,
    output pixel_t            host_rdata
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);

    pixel_t mem [DEPTH];

    // Contents are deliberately not reset; only the host read register is.
    always_ff @(posedge clk) begin
        if (we && (waddr < LIMIT)) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    assign rdata = (raddr < LIMIT) ? mem[raddr[IDX_W-1:0]] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_rdata <= '0;
        end else begin
            host_rdata <= (host_addr < LIMIT) ? mem[host_addr[IDX_W-1:0]] : '0;
        end
    end

endmodule

// File: rtl/skeleton_frame_store.sv
// Holds one NxN frame, streams it to the mask array and folds write-backs in
// until a pass leaves the frame unchanged or the pass limit is reached.
module skeleton_frame_store
    import skel_pkg::*;
#(
    parameter int N          = 8,
    parameter int ADDR_W     = 7,
    parameter int MAX_PASSES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    skeleton_frame_store_if.slave bus
);
    localparam int                NPIX       = N * N;
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W-1:0] NPIX_A     = ADDR_W'(NPIX);
    localparam logic [7:0]        PASS_LIMIT = 8'(MAX_PASSES);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    logic              changed, changed_nxt;
    logic [7:0]        pass_q, pass_nxt;
    logic              conv_q, conv_nxt;

    logic              wb_in_range;
    logic              wb_fire;
    logic              host_fire;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [ADDR_W-1:0] ram_raddr;
    pixel_t            ram_wdata;
    pixel_t            ram_rdata;

    logic              mask_we_q;
    logic [ADDR_W-1:0] mask_addr_q;
    pixel_t            mask_data_q;

    assign wb_in_range = bus.wb_addr < NPIX_A;
    assign wb_fire     = (state == COLLECT) && bus.wb_valid;
    assign host_fire   = (state == IDLE) && bus.host_we;

    // Host and write-back never compete: each is only live in its own state.
    assign ram_we    = host_fire || (wb_fire && wb_in_range);
    assign ram_waddr = host_fire ? bus.host_addr  : bus.wb_addr;
    assign ram_wdata = host_fire ? bus.host_wdata : bus.wb_data;
    assign ram_raddr = (state == COLLECT) ? bus.wb_addr : idx;

    frame_ram #(
        .DEPTH  (NPIX),
        .ADDR_W (ADDR_W)
    ) u_frame (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (ram_we),
        .waddr      (ram_waddr),
        .wdata      (ram_wdata),
        .raddr      (ram_raddr),
        .rdata      (ram_rdata),
        .host_addr  (bus.host_addr),
        .host_rdata (bus.host_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            changed <= 1'b0;
            pass_q  <= '0;
            conv_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            changed <= changed_nxt;
            pass_q  <= pass_nxt;
            conv_q  <= conv_nxt;
        end
    end

    // idx is the stream index in STREAM and the write-back beat counter in COLLECT.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        changed_nxt = changed;
        pass_nxt    = pass_q;
        conv_nxt    = conv_q;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nxt   = STREAM;
                    idx_nxt     = '0;
                    changed_nxt = 1'b0;
                    pass_nxt    = '0;
                    conv_nxt    = 1'b0;
                end
            end
            STREAM: begin
                if (idx == LAST_IDX) begin
                    state_nxt = COLLECT;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            COLLECT: begin
                if (bus.wb_valid) begin
                    // ram_rdata is the pre-write value of the addressed pixel.
                    if (wb_in_range && (bus.wb_data != ram_rdata)) begin
                        changed_nxt = 1'b1;
                    end
                    if (idx == LAST_IDX) begin
                        state_nxt = CHECK;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            CHECK: begin
                pass_nxt = pass_q + 8'd1;
                if (!changed) begin
                    state_nxt = DONE;
                    conv_nxt  = 1'b1;
                end else if ((pass_q + 8'd1) == PASS_LIMIT) begin
                    state_nxt = DONE;
                    conv_nxt  = 1'b0;
                end else begin
                    state_nxt   = STREAM;
                    changed_nxt = 1'b0;
                    idx_nxt     = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_we_q   <= 1'b0;
            mask_addr_q <= '0;
            mask_data_q <= '0;
        end else begin
            mask_we_q <= (state == STREAM);
            if (state == STREAM) begin
                mask_addr_q <= idx;
                mask_data_q <= ram_rdata;
            end
        end
    end

    assign bus.mask_we    = mask_we_q;
    assign bus.mask_addr  = mask_addr_q;
    assign bus.mask_data  = mask_data_q;
    assign bus.busy       = (state == STREAM) || (state == COLLECT) || (state == CHECK);
    assign bus.done       = (state == DONE);
    assign bus.pass_count = pass_q;
    assign bus.converged  = conv_q;

endmodule

// File: tb/tb_skeleton_frame_store.sv
// Scoreboard bench: stimulus pushes expected mask beats, job results and host reads;
// a negedge monitor pops and compares them against what the frame store presents.
module tb_skeleton_frame_store;

    localparam int N      = 8;
    localparam int ADDR_W = 7;
    localparam int MAXP   = 3;
    localparam int NPIX   = N * N;

    typedef struct {
        int a;
        int d;
    } beat_t;

    typedef struct {
        int passes;
        int conv;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rd_chk = 1'b0;

    int n_cmp = 0;
    int n_mis = 0;

    int    ref_frame [NPIX];
    beat_t exp_mask_q [$];
    res_t  exp_res_q [$];
    int    exp_rd_q [$];

    always #5 clk = ~clk;

    skeleton_frame_store_if #(.ADDR_W(ADDR_W)) bus ();

    skeleton_frame_store #(
        .N          (N),
        .ADDR_W     (ADDR_W),
        .MAX_PASSES (MAXP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_mis++;
        $display("FAIL %s: event did not occur", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        int    run_len;
        bit    done_seen;
        beat_t b;
        res_t  r;
        int    rd;
        run_len   = 0;
        done_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run_len   = 0;
                done_seen = 1'b0;
            end else begin
                if (bus.mask_we) begin
                    if (exp_mask_q.size() == 0) begin
                        n_cmp++;
                        n_mis++;
                        $display("FAIL mask_unexpected: beat at addr %0d, none expected", bus.mask_addr);
                    end else begin
                        b = exp_mask_q.pop_front();
                        chk("mask_addr", int'(bus.mask_addr), b.a);
                        chk("mask_data", int'(bus.mask_data), b.d);
                    end
                    run_len++;
                end else if (run_len != 0) begin
                    chk("mask_burst_len", run_len, NPIX);
                    run_len = 0;
                end
                if (bus.done && !done_seen) begin
                    done_seen = 1'b1;
                    if (exp_res_q.size() == 0) begin
                        n_cmp++;
                        n_mis++;
                        $display("FAIL done_unexpected: done with pass_count %0d", bus.pass_count);
                    end else begin
                        r = exp_res_q.pop_front();
                        chk("pass_count", int'(bus.pass_count), r.passes);
                        chk("converged", int'(bus.converged), r.conv);
                        chk("busy_in_done", int'(bus.busy), 0);
                    end
                end
                if (!bus.done) done_seen = 1'b0;
                if (rd_chk) begin
                    if (exp_rd_q.size() == 0) begin
                        n_cmp++;
                        n_mis++;
                        $display("FAIL host_read: no expected value queued");
                    end else begin
                        rd = exp_rd_q.pop_front();
                        chk("host_rdata", int'(bus.host_rdata), rd);
                    end
                end
            end
        end
    end

    // ---------------- reference model helpers ----------------
    task automatic push_stream();
        beat_t b;
        for (int i = 0; i < NPIX; i++) begin
            b.a = i;
            b.d = ref_frame[i];
            exp_mask_q.push_back(b);
        end
    endtask

    task automatic push_result(input int passes, input int conv);
        res_t r;
        r.passes = passes;
        r.conv   = conv;
        exp_res_q.push_back(r);
    endtask

    // Mask-array behaviour per mode: 0 echo, 1 clear pixel 10 on pass 1,
    // 2 invert pixel 0 every pass, 3 random edits on pass 1 only.
    function automatic int wb_val(input int mode, input int pass, input int a, input int cur);
        case (mode)
            1:       return (pass == 1 && a == 10) ? 0 : cur;
            2:       return (a == 0) ? (cur ^ 8'hFF) : cur;
            3:       return (pass == 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : cur;
            default: return cur;
        endcase
    endfunction

    task automatic host_write(input int a, input int d, input bit honoured);
        bus.host_we    = 1'b1;
        bus.host_addr  = ADDR_W'(a);
        bus.host_wdata = 8'(d);
        tick();
        bus.host_we = 1'b0;
        if (honoured) ref_frame[a] = d;
    endtask

    task automatic host_read(input int a);
        bus.host_addr = ADDR_W'(a);
        tick();
        exp_rd_q.push_back(ref_frame[a]);
        rd_chk = 1'b1;
        tick();
        rd_chk = 1'b0;
    endtask

    task automatic start_job(input int sw_addr, input int sw_data);
        if (sw_addr >= 0) begin
            bus.host_we    = 1'b1;
            bus.host_addr  = ADDR_W'(sw_addr);
            bus.host_wdata = 8'(sw_data);
            ref_frame[sw_addr] = sw_data;
        end
        push_stream();
        bus.start = 1'b1;
        tick();
        bus.start   = 1'b0;
        bus.host_we = 1'b0;
        chk("busy_after_start", int'(bus.busy), 1);
    endtask

    // Waits out one stream burst; optional interference lands only while still streaming.
    task automatic wait_stream(input bit interfere, output bit ok);
        int wait_n;
        bit seen;
        wait_n = 0;
        seen   = 1'b0;
        ok     = 1'b1;
        while (!(seen && !bus.mask_we) && wait_n < 400) begin
            if (bus.mask_we) seen = 1'b1;
            if (interfere && bus.mask_we && int'(bus.mask_addr) < 56) begin
                bus.host_we    = 1'b1;
                bus.host_addr  = ADDR_W'($urandom_range(0, NPIX - 1));
                bus.host_wdata = 8'($urandom_range(0, 255));
                bus.wb_valid   = 1'b1;
                bus.wb_addr    = ADDR_W'($urandom_range(0, NPIX - 1));
                bus.wb_data    = 8'($urandom_range(0, 255));
            end else begin
                bus.host_we  = 1'b0;
                bus.wb_valid = 1'b0;
            end
            tick();
            wait_n++;
        end
        bus.host_we  = 1'b0;
        bus.wb_valid = 1'b0;
        if (wait_n >= 400) begin
            fail_now("stream_timeout");
            ok = 1'b0;
        end
    endtask

    task automatic run_job(input int mode, input bit gaps, input bit bad, input bit shuf,
                           input bit interfere, input int sw_addr, input int sw_data);
        int passes, bad_j, a, d, t, j2, wait_n;
        int order [NPIX];
        bit changed, ok;
        start_job(sw_addr, sw_data);
        passes = 0;
        forever begin
            wait_stream(interfere, ok);
            if (!ok) return;
            for (int i = 0; i < NPIX; i++) order[i] = i;
            if (shuf) begin
                for (int i = NPIX - 1; i > 0; i--) begin
                    j2 = $urandom_range(0, i);
                    t = order[i]; order[i] = order[j2]; order[j2] = t;
                end
            end
            bad_j   = bad ? int'($urandom_range(0, NPIX - 1)) : -1;
            changed = 1'b0;
            for (int j = 0; j < NPIX; j++) begin
                if (gaps) begin
                    bus.wb_valid = 1'b0;
                    tick();
                end
                a = (j == bad_j) ? 70 : order[j];
                if (a < NPIX) begin
                    d = wb_val(mode, passes + 1, a, ref_frame[a]);
                    if (d != ref_frame[a]) changed = 1'b1;
                    ref_frame[a] = d;
                end else begin
                    d = $urandom_range(0, 255);
                end
                bus.wb_valid = 1'b1;
                bus.wb_addr  = ADDR_W'(a);
                bus.wb_data  = 8'(d);
                if (interfere && j == 10) bus.start = 1'b1;
                tick();
                bus.start = 1'b0;
            end
            bus.wb_valid = 1'b0;
            passes++;
            if (!changed) begin
                push_result(passes, 1);
                break;
            end else if (passes == MAXP) begin
                push_result(passes, 0);
                break;
            end
            push_stream();
        end
        wait_n = 0;
        while (!bus.done && wait_n < 50) begin
            tick();
            wait_n++;
        end
        if (!bus.done) fail_now("done_timeout");
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int wait_n;
        bus.host_we    = 1'b0;
        bus.host_addr  = '0;
        bus.host_wdata = '0;
        bus.start      = 1'b0;
        bus.wb_valid   = 1'b0;
        bus.wb_addr    = '0;
        bus.wb_data    = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_converged", int'(bus.converged), 0);
        chk("rst_mask_we", int'(bus.mask_we), 0);
        chk("rst_pass_count", int'(bus.pass_count), 0);
        chk("rst_mask_addr", int'(bus.mask_addr), 0);
        chk("rst_mask_data", int'(bus.mask_data), 0);
        chk("rst_host_rdata", int'(bus.host_rdata), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Identity frame, echoed back: one converged pass.
        for (int i = 0; i < NPIX; i++) host_write(i, i, 1'b1);
        run_job(0, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
        host_read(0);
        host_read(63);
        host_read(10);

        // Writes in DONE are ignored; pixel 10 cleared on pass 1 only.
        host_write(5, 8'hAA, 1'b0);
        run_job(1, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
        host_read(10);
        host_read(5);

        // Pixel 0 toggles forever: the pass limit ends the job unconverged.
        run_job(2, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
        host_read(0);

        // Reset in the middle of a stream.
        start_job(-1, 0);
        wait_n = 0;
        while (!(bus.mask_we && int'(bus.mask_addr) == 20) && wait_n < 100) begin
            tick();
            wait_n++;
        end
        if (wait_n >= 100) fail_now("reach_addr20");
        rst_n = 1'b0;
        #1;
        chk("midrst_mask_we", int'(bus.mask_we), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_pass_count", int'(bus.pass_count), 0);
        chk("midrst_done", int'(bus.done), 0);
        exp_mask_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Fresh random frame; last pixel written in the start cycle; gaps,
        // a dropped out-of-range beat and interference during stream/collect.
        for (int i = 0; i < NPIX - 1; i++) host_write(i, $urandom_range(0, 255), 1'b1);
        run_job(3, 1'b1, 1'b1, 1'b0, 1'b1, NPIX - 1, $urandom_range(0, 255));
        for (int k = 0; k < 4; k++) host_read($urandom_range(0, NPIX - 1));
        host_read(NPIX - 1);

        for (int r = 0; r < 3; r++) begin
            run_job(3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                    1'($urandom_range(0, 1)), -1, 0);
            for (int k = 0; k < 3; k++) host_read($urandom_range(0, NPIX - 1));
        end

        repeat (4) tick();
        if (exp_mask_q.size() != 0) chk("mask_beats_left", exp_mask_q.size(), 0);
        if (exp_res_q.size() != 0) chk("results_left", exp_res_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
